// File: rtl/bit_mixer_pkg.sv
// Shared types and constants for the bit mixer datapath element.
package bit_mixer_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MIX_PASS  = 2'd0,
    MIX_XOR   = 2'd1,
    MIX_INTLV = 2'd2,
    MIX_ROTL  = 2'd3
  } mix_mode_t;

endpackage : bit_mixer_pkg

// File: rtl/bit_mixer_core.sv
// Combinational mixer: combines operands a and b under the selected mode.
module bit_mixer_core
  import bit_mixer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mix_mode_t        mode,
  output logic [WIDTH-1:0] result
);

  localparam int SH_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("bit_mixer_core: WIDTH must be even and >= 2");
  end

  int unsigned rot_amt;

  // Rotation amount uses only the low bits of b, reduced modulo WIDTH
  // so non-power-of-two widths still rotate within range.
  assign rot_amt = 32'(b[SH_W-1:0]) % WIDTH;

  // Select the operation for the current beat.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    result = '0;
    case (mode)
      MIX_PASS: result = a;
      MIX_XOR:  result = a ^ b;
      MIX_INTLV: begin
        for (int i = 0; i < WIDTH / 2; i++) begin
          result[2*i]   = a[i];
          result[2*i+1] = b[i];
        end
      end
      MIX_ROTL: result = (a << rot_amt) | (a >> (WIDTH - rot_amt));
      default:  result = a;
    endcase
  end

endmodule : bit_mixer_core

// File: rtl/bit_mixer_pipe.sv
// Pipelined mixer: core result registered behind a valid/ready handshake
// with a 2-entry (output + skid) buffer and an output-transaction counter.
module bit_mixer_pipe
  import bit_mixer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [MODE_W-1:0]  mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   C,
  output logic [COUNT_W-1:0] out_count
);

  logic [WIDTH-1:0] mix_result;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             drain;

  logic             out_valid_d;
  logic [WIDTH-1:0] c_d;
  logic             skid_valid_d;
  logic             skid_load;

  bit_mixer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (A),
    .b      (B),
    .mode   (mix_mode_t'(mode)),
    .result (mix_result)
  );

  // in_ready comes straight from the skid flop, so there is no
  // combinational path from out_ready back to the producer.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Decide where an accepted beat lands and how the buffer drains.
  always_comb begin
    out_valid_d  = out_valid;
    c_d          = C;
    skid_valid_d = skid_valid;
    skid_load    = 1'b0;
    if (skid_valid) begin
      // Skid full implies the output holds a beat; drain moves skid forward.
      if (out_ready) begin
        c_d          = skid_data;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        c_d         = mix_result;
        out_valid_d = 1'b1;
      end else begin
        skid_load    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state, output register and counter, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      C          <= '0;
      skid_valid <= 1'b0;
      out_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      out_valid  <= out_valid_d;
      C          <= c_d;
      skid_valid <= skid_valid_d;
      if (drain) begin
        out_count <= out_count + COUNT_W'(1);
      end
    end
  end

  // Skid payload storage.
  // NOTE: the payload needs no reset; skid_valid alone says whether it
  // is meaningful, and leaving it unreset keeps it a plain enable flop.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data <= mix_result;
    end
  end

endmodule : bit_mixer_pipe

// File: tb/tb_bit_mixer_pipe.sv
// Self-checking bench for bit_mixer_pipe (WIDTH=8, COUNT_W=4).
module tb_bit_mixer_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  C;
  logic [CW-1:0] out_count;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_model = 0;
  logic [W-1:0] exp_q[$];

  bit_mixer_pipe #(
    .WIDTH   (W),
    .COUNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference mixer written from the mode definitions.
  function automatic logic [W-1:0] mix_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] m);
    logic [2*W-1:0] wide;
    logic [W-1:0]   r;
    int             amt;
    r = '0;
    case (m)
      2'd0: r = a;
      2'd1: r = a ^ b;
      2'd2: for (int i = 0; i < W / 2; i++) begin
              r[2*i]   = a[i];
              r[2*i+1] = b[i];
            end
      default: begin
        amt  = int'(b) % W;
        wide = {8'h00, a} << amt;
        r    = wide[W-1:0] | wide[2*W-1:W];
      end
    endcase
    return r;
  endfunction

  // One clock cycle; called just after a falling edge with inputs set.
  task automatic tick(output logic acc);
    logic         drn;
    logic         hold;
    logic [W-1:0] c_seen;
    acc    = in_valid && in_ready;
    drn    = out_valid && out_ready;
    hold   = out_valid && !out_ready;
    c_seen = C;
    if (drn) begin
      if (exp_q.size() == 0) check("spurious_out", 32'(c_seen), 32'hFFFF_FFFF);
      else check("data", 32'(c_seen), 32'(exp_q.pop_front()));
      cnt_model++;
    end
    if (acc) exp_q.push_back(mix_ref(A, B, mode));
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(C), 32'(c_seen));
    end
    check("count", 32'(out_count), 32'(cnt_model % (1 << CW)));
  endtask

  task automatic drain_all();
    logic acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick(acc);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Apply reset asynchronously mid low phase and check it acts at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_c"}, 32'(C), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_count"}, 32'(out_count), 32'd0);
    exp_q.delete();
    cnt_model = 0;
    in_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic directed(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input string tag);
    logic acc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = a; B = b; mode = m;
    tick(acc);
    check({tag, "_acc"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_c"}, 32'(C), 32'(exp));
    tick(acc);
  endtask

  initial begin
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; mode = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", 32'(C), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;

    // Directed operations with known answers.
    directed(2'd1, 8'hA5, 8'h0F, 8'hAA, "xor");
    check("xor_count", 32'(out_count), 32'd1);
    directed(2'd2, 8'h0F, 8'h00, 8'h55, "intlv");
    directed(2'd3, 8'h81, 8'h03, 8'h0C, "rotl");
    directed(2'd0, 8'h3C, 8'h99, 8'h3C, "pass");
    directed(2'd3, 8'h81, 8'hF9, 8'h03, "rotl_hib");

    // Backpressure: X1 held, X2 in skid, X3 stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; A = 8'h11; B = 8'h22; mode = 2'd0;
    tick(acc);
    check("bp_x1_acc", 32'(acc), 32'd1);
    A = 8'h33; B = 8'h44; mode = 2'd1;
    tick(acc);
    check("bp_x2_acc", 32'(acc), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    A = 8'h5A; B = 8'h01; mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check("bp_x3_stall", 32'(acc), 32'd0);
      check("bp_c_x1", 32'(C), 32'h11);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_stream_valid", 32'(out_valid), 32'd1);
      tick(acc);
      if (acc) in_valid = 1'b0;
    end
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_queue", 32'(exp_q.size()), 32'd0);

    // Back-to-back 16 beats, alternating modes.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom); mode = 2'(i % 4);
      tick(acc);
      check("b2b_acc", 32'(acc), 32'd1);
      check("b2b_valid", 32'(out_valid), 32'd1);
    end
    drain_all();

    // Random traffic, then reset mid-stream.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A = W'($urandom); B = W'($urandom); mode = 2'($urandom);
      tick(acc);
    end
    out_ready = 1'b0;
    async_reset("midrst");

    // Counter wrap: 17 handshakes with COUNT_W=4.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom); mode = 2'($urandom);
      tick(acc);
    end
    drain_all();
    check("wrap_count", 32'(out_count), 32'd1);

    // Reset while the skid is full.
    out_ready = 1'b0;
    in_valid = 1'b1; A = 8'hC3; B = 8'h5A; mode = 2'd1;
    tick(acc);
    tick(acc);
    check("skidfull_in_ready", 32'(in_ready), 32'd0);
    async_reset("skidrst");
    check("skidrst_in_ready_after", 32'(in_ready), 32'd1);
    directed(2'd1, 8'hA5, 8'h0F, 8'hAA, "post_rst");
    check("post_rst_count", 32'(out_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bit_mixer_pipe

// File: doc/bit_mixer_pipe.md
Name: bit_mixer_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 4-bit mixer element.
- Combines two WIDTH-bit operands A and B under a per-transaction mode: pass, XOR, interleave or rotate.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput with no combinational ready path.
- Sits between streaming producer and consumer stages in catalog datapaths; also keeps a count of output transactions.

Parameters:
- WIDTH, 4, operand/result width; must be even and >= 2.
- COUNT_W, 8, width of the output-transaction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer has a beat on A/B/mode.
- in_ready  output  1  block can accept a beat; registered.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- mode  input  2  operation for this beat: 0 PASS, 1 XOR, 2 INTLV, 3 ROTL.
- out_valid  output  1  C holds a valid result.
- out_ready  input  1  consumer accepts C.
- C  output  WIDTH  result.
- out_count  output  COUNT_W  number of completed output handshakes, wrapping.

Behaviour:
- Reset (rst_n low, takes effect asynchronously): out_valid=0, C=0, skid empty, in_ready=1, out_count=0. Any beat in flight is discarded. First acceptance is allowed on the first clk edge after rst_n rises.
- Input handshake: a beat is accepted on a clk edge where in_valid && in_ready. Output handshake: a beat completes on a clk edge where out_valid && out_ready.
- Result is computed combinationally from the accepted A, B and mode, then registered. Mode is captured per beat, so changing mode between beats never affects a beat already accepted.
- Modes:
  - PASS: C=A.
  - XOR: C=A^B.
  - INTLV: for i in 0..WIDTH/2-1, C[2i]=A[i] and C[2i+1]=B[i]. The upper halves of A and B are ignored.
  - ROTL: C = A rotated left by B mod WIDTH. Only the low clog2(WIDTH) bits of B are used.
- Latency: a beat accepted at edge N appears on C with out_valid=1 after edge N (1 cycle) when the output register is empty or draining.
- Throughput: one beat per cycle when out_ready stays high. Simultaneous accept and drain in the same cycle is legal; the output register loads the new beat and there is no bubble.
- Skid buffer:
  - If the output register holds an undrained beat (out_valid && !out_ready) and a beat is accepted, that beat goes into the skid register.
  - in_ready drops to 0 on the following edge and stays 0 while the skid is full.
  - When the output drains, the skid beat moves into the output register on the same edge, and in_ready returns to 1 on that edge.
- Ordering: beats leave in acceptance order; none dropped or duplicated.
- Stability: while out_valid && !out_ready, C and out_valid hold stable.
- out_count: increments by 1 per output handshake and wraps from 2^COUNT_W-1 to 0. Never changes on input-only cycles.
- C holds its last value when out_valid=0. Only reset zeroes it.

Decomposition:
- Package bit_mixer_pkg holds:
  - typedef enum logic [1:0] mix_mode_t {MIX_PASS, MIX_XOR, MIX_INTLV, MIX_ROTL}
  - a localparam for the mode width
- Sub-module bit_mixer_core: purely combinational (A, B, mode) -> result, parametrised by WIDTH. The bit_mixer_pipe top wraps the core with the output register, skid register, handshake and counter.

Test Plan:
- Reset: hold rst_n low mid-stream -> out_valid=0, C=0, in_ready=1, out_count=0 asynchronously, without waiting for a clk edge.
- WIDTH=8, XOR, A=8'hA5, B=8'h0F, out_ready=1 -> C=8'hAA with out_valid=1 one cycle after acceptance; out_count=1 after the handshake.
- WIDTH=8, INTLV, A=8'h0F, B=8'h00 -> C=8'h55; ROTL, A=8'h81, B=8'h03 -> C=8'h0C; PASS, A=8'h3C -> C=8'h3C.
- Backpressure: out_ready=0, send beats X1/X2/X3 -> X1 held on C, X2 in skid, in_ready=0, X3 stalled at input. Raise out_ready -> C shows X1, X2, X3 on consecutive cycles; no loss or duplication.
- Back-to-back 16 beats with alternating modes, out_ready=1 -> one result per cycle, each result using its own beat's mode.
- COUNT_W=4, 17 output handshakes -> out_count=1 (wrap). Asserting rst_n low while the skid is full -> all state is cleared and in_ready=1.
